ysyx_22050612_fetch: RTL
========================

# ysyx_22050612_fetch

Instruction fetch stage for the ysyx_22050612 core: owns the program counter, issues instruction-memory reads over a valid/ready request channel, and presents each fetched 32-bit instruction with its PC to the decode stage (IDU) over a valid/ready handshake. It sits directly upstream of the IDU. It replaces the bare PC register plus externally supplied `inst` with a handshaked, redirectable fetch path. Branch and jump targets from the EXU enter via a redirect port, which squashes any in-flight or buffered fetch.

## Interface
Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- mem_req_valid  output  1  fetch request valid.
- mem_req_ready  input  1  memory accepts the request this cycle.
- mem_req_addr  output  64  fetch address; always current PC, bits [1:0] = 0.
- mem_rsp_valid  input  1  response data valid (one cycle per accepted request, in order).
- mem_rsp_data  input  32  fetched instruction word.
- out_valid  output  1  instruction available to IDU.
- out_ready  input  1  IDU accepts the instruction.
- out_inst  output  32  buffered instruction.
- out_pc  output  64  PC of out_inst.
- redirect_valid  input  1  EXU redirect strobe.
- redirect_pc  input  64  new fetch target; bits [1:0] ignored (treated as 0).
- fetch_cnt  output  64  number of completed out handshakes since reset.

## Operation
- State machine: IDLE, REQ, WAIT, HOLD. A 1-bit squash flag records whether the outstanding request is stale.
- IDLE: entered on reset; unconditionally moves to REQ on the next clk edge.
- REQ: mem_req_valid=1, mem_req_addr=pc. On handshake (mem_req_ready=1), go to WAIT. Memory samples the address only on handshake, so the address may change while unaccepted.
- WAIT: mem_req_valid=0. On mem_rsp_valid:
  - If squash=1: discard the data, clear squash, go to REQ.
  - Otherwise: capture mem_rsp_data into out_inst and pc into out_pc, then go to HOLD.
- HOLD: out_valid=1; out_inst and out_pc are stable. On out_ready: pc<=pc+4 (64-bit wrap), fetch_cnt+=1, go to REQ.
- Redirect (redirect_valid=1), highest priority over all other PC updates. In every case pc<={redirect_pc[63:2],2'b00}.
  - IDLE: pc updated; state proceeds to REQ.
  - REQ without handshake: stay in REQ; the new address appears next cycle.
  - REQ with handshake in the same cycle: go to WAIT with squash=1.
  - WAIT: set squash=1. If mem_rsp_valid arrives in the same cycle, that response is discarded and the state goes to REQ with squash cleared.
  - HOLD: drop the buffer, out_valid=0 next cycle, go to REQ. If out_ready=1 in the same cycle, the transfer still counts (fetch_cnt increments). The IDU/EXU discards it, and pc takes redirect_pc, not pc+4.
- At most one request outstanding; no prefetch.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, squash=0, mem_req_valid=0, out_valid=0, out_inst=0, out_pc=0, fetch_cnt=0.
- Reset mid-operation: all state returns to reset values immediately (async). A response arriving after reset release for a pre-reset request is not expected; memory is reset on the same rst.
- First request: mem_req_valid=1 in the first cycle after rst deasserts (IDLE→REQ edge).
- Best-case latency, with req_ready and rsp_valid each returned one cycle after the request:
  - Cycle 0: request accepted.
  - Cycle 1: response arrives.
  - Cycle 2: out_valid=1.
  - Throughput with out_ready held at 1: one instruction per 3 cycles.
- out_valid, out_inst, out_pc and mem_req_valid are driven from registered state only; there is no combinational path from inputs to outputs. mem_req_addr is registered pc.
- Redirect takes effect on the edge where redirect_valid is sampled. The new address is visible on mem_req_addr the following cycle.

## Test plan
- Reset/startup: hold rst=0 for 3 cycles, release, keep req_ready=1 and respond 1 cycle later with 32'h00000413 → mem_req_addr=64'h80000000, out_valid=1 with out_pc=64'h80000000 two cycles after acceptance, fetch_cnt=0.
- Sequential stream: always-ready memory and IDU over 10 instructions → out_pc sequence 0x80000000, +4 … 0x80000024, out_valid high every third cycle, fetch_cnt=10.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD → out_inst/out_pc stable, mem_req_valid=0, pc unchanged; release → pc+4 request next cycle.
- Redirect in WAIT: redirect_pc=64'h80001002 while a request to 0x80000008 is outstanding → that response is discarded (out_valid stays 0), next request address=64'h80001000.
- Redirect in HOLD with out_ready=1 in the same cycle → fetch_cnt increments, next mem_req_addr=redirect target, not pc+4.
- Async reset mid-WAIT: pull rst low for 1 cycle between edges → outputs go to reset values immediately; after release the first request is to RESET_PC.

Source files
------------

// File: rtl/ysyx_22050612_fetch.sv
// ysyx_22050612_fetch: redirectable PC/fetch stage feeding the IDU over valid/ready
// Ports: clk, rst (async active-low); mem_req_* request channel (addr = pc);
// mem_rsp_* in-order response; out_* instruction+pc to IDU; redirect_* from EXU;
// fetch_cnt counts completed out handshakes.
module ysyx_22050612_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [63:0] out_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [63:0] fetch_cnt
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;
  state_e state_q, state_d;
  logic [63:0] pc_q, pc_d, opc_q, opc_d, cnt_q, cnt_d;
  logic [31:0] inst_q, inst_d;
  logic squash_q, squash_d;
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opc_d    = opc_q;
    inst_d   = inst_q;
    cnt_d    = cnt_q;
    squash_d = squash_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: if (mem_req_ready) begin
        state_d  = WAIT;
        squash_d = redirect_valid;
      end
      WAIT: if (mem_rsp_valid) begin
        if (squash_q || redirect_valid) begin
          squash_d = 1'b0;
          state_d  = REQ;
        end else begin
          inst_d  = mem_rsp_data;
          opc_d   = pc_q;
          state_d = HOLD;
        end
      end else if (redirect_valid) squash_d = 1'b1;
      HOLD: begin
        if (out_ready) begin
          pc_d    = pc_q + 64'd4;
          cnt_d   = cnt_q + 64'd1;
          state_d = REQ;
        end
        if (redirect_valid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
    if (redirect_valid) pc_d = {redirect_pc[63:2], 2'b00};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      opc_q    <= '0;
      inst_q   <= '0;
      cnt_q    <= '0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opc_q    <= opc_d;
      inst_q   <= inst_d;
      cnt_q    <= cnt_d;
      squash_q <= squash_d;
    end
  end
  assign mem_req_valid = state_q == REQ;
  assign mem_req_addr  = pc_q;
  assign out_valid     = state_q == HOLD;
  assign out_inst      = inst_q;
  assign out_pc        = opc_q;
  assign fetch_cnt     = cnt_q;
endmodule
